scroll_load_ctrl: RTL and testbench
===================================

// Module: scroll_load_ctrl
// PURPOSE
// - Upstream control stage for the 8-bit TTL-style scroll counter (n8bit_counter-style port set).
// - Holds CPU-written 9-bit horizontal scroll values, double-buffered and latched once per frame.
// - Generates that counter's preload (P, load_n), enables (ent_n/enp_n) and direction once per line.
// - Consumes the counter's Q to track bit 8 (scroll_msb) across 8-bit wrap-around.
// PARAMETERS
// - RST_SCROLL  9'h000  value loaded into pending and shadow scroll registers on reset
// PORTS
// clk        in   1  system clock; all state updates on posedge clk
// Reset_n    in   1  synchronous, active-low reset; takes precedence over everything
// cen        in   1  pixel clock enable; rising edge detected internally (cen & !last_cen)
// cpu_wr     in   1  CPU write strobe, single clk cycle, independent of cen
// cpu_addr   in   2  0: scroll[7:0]  1: scroll[8] (din[0])  2: ctrl (din[0]=scroll_en)  3: ignored
// cpu_din    in   8  CPU write data
// hblank     in   1  horizontal blank, active high, sampled on cen_rise only
// vblank     in   1  vertical blank, active high, sampled on cen_rise only
// flip       in   1  screen flip (used only with SCROLL_FLIP_EN)
// cnt_q      in   8  Q of the downstream counter
// load_n     out  1  to counter load_n, active low
// ent_n      out  1  to counter ent_n, active low
// enp_n      out  1  to counter enp_n, active low (always equal to ent_n)
// direction  out  1  to counter direction, 1 = up
// P          out  8  to counter P (preload value)
// scroll_msb out  1  bit 8 of the effective scroll position
// BEHAVIOUR
// - Reset values: load_n=1, ent_n=enp_n=1, direction=1, P=0, scroll_msb=0, scroll_en=0, state IDLE,
//   pending=shadow=RST_SCROLL, edge history regs (last_cen, hb_d, vb_d)=0.
// - All outputs are registered; they change only on the clk following a detected cen_rise.
// - CPU writes land in the pending regs on the same clk, cen ignored. Addr 3 writes have no effect.
// - Frame latch: on cen_rise where vblank=1 and vb_d=0, shadow <= pending.
//   A write in that same clk is NOT captured; it lands in the next frame.
// - FSM, advancing only on cen_rise:
//   IDLE    -> PRELOAD when hblank=0, hb_d=1, vblank=0.
//              P <= shadow[7:0], load_n <= 0, scroll_msb <= shadow[8].
//   PRELOAD -> RUN on the next cen_rise. load_n <= 1, so load_n is low for exactly one cen period.
//              ent_n/enp_n <= !scroll_en.
//   RUN     -> IDLE on cen_rise with hblank=1 or vblank=1. ent_n/enp_n <= 1.
//   RUN, stays: if ent_n=0 and cnt_q == wrap value (8'hFF up, 8'h00 down), scroll_msb toggles.
//   A RUN line with scroll_en=0 still preloads but never counts; scroll_msb holds.
// - vblank=1 suppresses PRELOAD entry.
// - hblank falling on the same cen_rise as vblank rising: vblank wins, state stays IDLE.
// - cen held high: only one cen_rise; no further advance until cen goes low, then high.
// - Reset mid-line: outputs return to reset values on that clk, regardless of cen. FSM -> IDLE.
// CONFIGURATION
// - SCROLL_FLIP_EN defined:
//   flip sampled at PRELOAD entry. flip=1: direction=0, P=~shadow[7:0], scroll_msb=~shadow[8],
//   wrap detect on 8'h00. flip=0: identical to the undefined case.
// - SCROLL_FLIP_EN undefined: direction tied 1, flip input ignored (unused).
// STRUCTURE
// - scroll_pkg: typedef enum logic [1:0] {IDLE, PRELOAD, RUN} sl_state_t.
//   Address localparams SL_ADDR_LO=2'd0, SL_ADDR_HI=2'd1, SL_ADDR_CTRL=2'd2.
//   Wrap constants SL_WRAP_UP=8'hFF, SL_WRAP_DN=8'h00.
// - Sub-module cen_rise_det: last_cen register plus rise pulse. Its reset is Reset_n, synchronous.
// TESTING
// 1. Hold Reset_n=0 for 3 clk while cen toggles:
//    load_n=1, ent_n=enp_n=1, direction=1, P=0, scroll_msb=0 throughout.
// 2. Write addr0=0x34, addr1=0x01, addr2=0x01, then pulse vblank:
//    next line hblank fall gives P=0x34, load_n=0 for exactly one cen period, scroll_msb=1.
//    ent_n=0 follows on the next cen_rise.
// 3. Shadow=0x0FE, scroll_en=1, a bench counter model driven by the outputs:
//    cnt_q reaches 0xFF during RUN -> scroll_msb 0->1 on the next cen_rise; second wrap -> 1->0.
// 4. cpu_wr addr0=0x55 on the same clk as the vblank-rise cen_rise:
//    shadow keeps its old low byte; 0x55 appears as P only after the following vblank.
// 5. Assert Reset_n=0 for 1 clk while in RUN:
//    ent_n=1, load_n=1, P=0 on the next clk; no PRELOAD until the next hblank fall.
// 6. (SCROLL_FLIP_EN) flip=1, shadow=0x034: P=0xCB, direction=0, scroll_msb=1.
//    cnt_q=0x00 in RUN toggles scroll_msb.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared types and constants for the scroll load controller.
// Contents: FSM state type, CPU register addresses, counter wrap values and a
// helper that picks the wrap value for the current count direction.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRELOAD,
    RUN
  } sl_state_t;

  localparam logic [1:0] SL_ADDR_LO   = 2'd0;
  localparam logic [1:0] SL_ADDR_HI   = 2'd1;
  localparam logic [1:0] SL_ADDR_CTRL = 2'd2;

  localparam logic [7:0] SL_WRAP_UP = 8'hFF;
  localparam logic [7:0] SL_WRAP_DN = 8'h00;

  // Count value at which the downstream 8-bit counter wraps on the next enable.
  function automatic logic [7:0] sl_wrap(input logic up);
    return up ? SL_WRAP_UP : SL_WRAP_DN;
  endfunction

endpackage

// File: rtl/scroll_load_ctrl_if.sv
// Bus bundle between the scroll load controller and its surroundings.
// Carries the CPU write port, the video timing strobes, the flip input and the
// full port set of the downstream TTL-style 8-bit counter (P, load_n, ent_n,
// enp_n, direction, Q) plus the tracked scroll_msb.
//   slave  : controller view (CPU/timing/cnt_q in, counter controls out)
//   master : environment view (the opposite directions)
interface scroll_load_ctrl_if;

  logic       cpu_wr;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       hblank;
  logic       vblank;
  logic       flip;
  logic [7:0] cnt_q;
  logic       load_n;
  logic       ent_n;
  logic       enp_n;
  logic       direction;
  logic [7:0] P;
  logic       scroll_msb;

  modport slave (
    input  cpu_wr, cpu_addr, cpu_din, hblank, vblank, flip, cnt_q,
    output load_n, ent_n, enp_n, direction, P, scroll_msb
  );

  modport master (
    output cpu_wr, cpu_addr, cpu_din, hblank, vblank, flip, cnt_q,
    input  load_n, ent_n, enp_n, direction, P, scroll_msb
  );

endinterface

// File: rtl/scroll_load_ctrl_cen_rise_det.sv
// Rising-edge detector for the pixel clock enable.
// Ports:
//   clk     in  system clock
//   Reset_n in  synchronous active-low reset (clears the history bit)
//   cen     in  pixel clock enable level
//   rise    out one-clk pulse on the first clk that sees cen high after low
module cen_rise_det (
  input  logic clk,
  input  logic Reset_n,
  input  logic cen,
  output logic rise
);

  logic last_cen_q;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      last_cen_q <= 1'b0;
    end else begin
      last_cen_q <= cen;
    end
  end

  assign rise = cen & ~last_cen_q;

endmodule

// File: rtl/scroll_load_ctrl.sv
// Upstream control stage for the 8-bit scroll counter.
// Holds CPU-written 9-bit horizontal scroll values (pending -> shadow, latched
// at each vblank rise), preloads the counter once per line, enables it for the
// visible part of the line and follows Q to keep bit 8 of the scroll position.
// Ports:
//   clk     in  system clock
//   Reset_n in  synchronous active-low reset, overrides everything
//   cen     in  pixel clock enable; only its rising edge advances the line logic
//   bus     slave modport of scroll_load_ctrl_if (CPU port, hblank/vblank,
//           flip, cnt_q in; P, load_n, ent_n, enp_n, direction, scroll_msb out)
// Parameter:
//   RST_SCROLL reset value of the pending and shadow scroll registers
// Build option:
//   SCROLL_FLIP_EN  when defined, flip (sampled at line start) makes the counter
//                   run down from the inverted scroll value; otherwise direction
//                   is fixed up and flip is ignored.
module scroll_load_ctrl
  import scroll_pkg::*;
#(
  parameter logic [8:0] RST_SCROLL = 9'h000
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 cen,
  scroll_load_ctrl_if.slave    bus
);

  logic       cen_rise;
  logic [8:0] pending_q, shadow_q;
  logic       scroll_en_q;
  logic       hb_q, vb_q;
  logic       line_start, line_end;
  logic [7:0] wrap_val;
  logic       flip_sel;

  sl_state_t  state_q, state_d;
  logic [7:0] p_q, p_d;
  logic       load_n_q, load_n_d;
  logic       ent_n_q, ent_n_d;
  logic       msb_q, msb_d;
  logic       dir_q, dir_d;

  cen_rise_det u_cen_rise_det (
    .clk     (clk),
    .Reset_n (Reset_n),
    .cen     (cen),
    .rise    (cen_rise)
  );

`ifdef SCROLL_FLIP_EN
  assign flip_sel = bus.flip;
`else
  assign flip_sel = 1'b0;
  logic unused_flip;
  assign unused_flip = bus.flip;
`endif

  // vblank blocks line start even when hblank falls on the same enable.
  assign line_start = ~bus.hblank & hb_q & ~bus.vblank;
  assign line_end   = bus.hblank | bus.vblank;
  assign wrap_val   = sl_wrap(dir_q);

  // CPU registers, timing history and the per-frame shadow latch.
  // A write on the latch clk updates pending only, so it shows up next frame.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      pending_q   <= RST_SCROLL;
      shadow_q    <= RST_SCROLL;
      scroll_en_q <= 1'b0;
      hb_q        <= 1'b0;
      vb_q        <= 1'b0;
    end else begin
      if (bus.cpu_wr) begin
        case (bus.cpu_addr)
          SL_ADDR_LO:   pending_q[7:0] <= bus.cpu_din;
          SL_ADDR_HI:   pending_q[8]   <= bus.cpu_din[0];
          SL_ADDR_CTRL: scroll_en_q    <= bus.cpu_din[0];
          default:      ;
        endcase
      end
      if (cen_rise) begin
        hb_q <= bus.hblank;
        vb_q <= bus.vblank;
        if (bus.vblank && !vb_q) begin
          shadow_q <= pending_q;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (cen_rise) begin
      case (state_q)
        IDLE:    if (line_start) state_d = PRELOAD;
        PRELOAD: state_d = RUN;
        RUN:     if (line_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs (next values of the registered counter controls)
  always_comb begin
    p_d      = p_q;
    load_n_d = load_n_q;
    ent_n_d  = ent_n_q;
    msb_d    = msb_q;
    dir_d    = dir_q;
    if (cen_rise) begin
      case (state_q)
        IDLE: begin
          if (line_start) begin
            p_d      = shadow_q[7:0] ^ {8{flip_sel}};
            msb_d    = shadow_q[8] ^ flip_sel;
            dir_d    = ~flip_sel;
            load_n_d = 1'b0;
          end
        end
        PRELOAD: begin
          load_n_d = 1'b1;
          ent_n_d  = ~scroll_en_q;
        end
        RUN: begin
          if (line_end) begin
            ent_n_d = 1'b1;
          end else if (!ent_n_q && bus.cnt_q == wrap_val) begin
            // Counter wraps on this enable, so the 9th position bit flips.
            msb_d = ~msb_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      p_q      <= 8'h00;
      load_n_q <= 1'b1;
      ent_n_q  <= 1'b1;
      msb_q    <= 1'b0;
      dir_q    <= 1'b1;
    end else begin
      p_q      <= p_d;
      load_n_q <= load_n_d;
      ent_n_q  <= ent_n_d;
      msb_q    <= msb_d;
      dir_q    <= dir_d;
    end
  end

  assign bus.P          = p_q;
  assign bus.load_n     = load_n_q;
  assign bus.ent_n      = ent_n_q;
  assign bus.enp_n      = ent_n_q;
  assign bus.scroll_msb = msb_q;
  assign bus.direction  = dir_q;

endmodule

// File: tb/tb_scroll_load_ctrl.sv
module tb_scroll_load_ctrl;
  import scroll_pkg::*;

  logic clk;
  logic Reset_n;
  logic cen;

  scroll_load_ctrl_if bus ();

  scroll_load_ctrl #(
    .RST_SCROLL (9'h000)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .cen     (cen),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the downstream 8-bit counter, stepping on each cen rise.
  logic [7:0] cnt   = 8'h00;
  logic       cen_m = 1'b0;
  always @(posedge clk) begin
    cen_m <= cen;
    if (cen && !cen_m) begin
      if (!bus.load_n) cnt <= bus.P;
      else if (!bus.ent_n && !bus.enp_n) cnt <= bus.direction ? cnt + 8'd1 : cnt - 8'd1;
    end
  end
  assign bus.cnt_q = cnt;

  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Packs {P, load_n, ent_n, enp_n, scroll_msb, direction}.
  function automatic logic [12:0] ev(input logic [7:0] p, input logic ld, input logic en,
                                     input logic msb, input logic dir);
    return {p, ld, en, en, msb, dir};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.P, bus.load_n, bus.ent_n, bus.enp_n, bus.scroll_msb, bus.direction};
  endfunction

  task automatic pulse();
    @(negedge clk) cen = 1'b1;
    @(negedge clk) cen = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
    @(negedge clk);
    bus.cpu_wr = 1'b0;
  endtask

  task automatic frame_latch();
    bus.vblank = 1'b1; pulse();
    bus.vblank = 1'b0; pulse();
  endtask

  task automatic test_reset();
    exp_t e;
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{name: "reset", v: ev(8'h00, 1'b1, 1'b1, 1'b0, 1'b1)});
      @(negedge clk) cen = ~cen;
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e.v) begin
        errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v);
      end
    end
    cen = 1'b0;
    @(negedge clk) Reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preload();
    exp_t e;
    cpu_write(SL_ADDR_LO, 8'h34);
    cpu_write(SL_ADDR_HI, 8'h01);
    cpu_write(SL_ADDR_CTRL, 8'h01);
    cpu_write(2'd3, 8'h00);  // must not clear scroll_en
    frame_latch();
    exp_q.push_back('{name: "idle", v: ev(8'h00, 1'b1, 1'b1, 1'b0, 1'b1)});
    exp_q.push_back('{name: "preload", v: ev(8'h34, 1'b0, 1'b1, 1'b1, 1'b1)});
    exp_q.push_back('{name: "preload_hold", v: ev(8'h34, 1'b0, 1'b1, 1'b1, 1'b1)});
    exp_q.push_back('{name: "run_entry", v: ev(8'h34, 1'b1, 1'b0, 1'b1, 1'b1)});
    bus.hblank = 1'b1; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    bus.hblank = 1'b0; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    repeat (2) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_cen_held();
    exp_t e;
    // End the line with cen stuck high, then present a line start while still high.
    exp_q.push_back('{name: "cen_held", v: ev(8'h34, 1'b1, 1'b1, 1'b1, 1'b1)});
    exp_q.push_back('{name: "cen_release", v: ev(8'h34, 1'b1, 1'b1, 1'b1, 1'b1)});
    exp_q.push_back('{name: "vblank_wins", v: ev(8'h34, 1'b1, 1'b1, 1'b1, 1'b1)});
    bus.hblank = 1'b1;
    @(negedge clk) cen = 1'b1;
    repeat (4) @(negedge clk);
    bus.hblank = 1'b0;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    bus.hblank = 1'b1; cen = 1'b0;
    @(negedge clk);
    pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    bus.hblank = 1'b0; bus.vblank = 1'b1; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    bus.vblank = 1'b0; bus.hblank = 1'b1; pulse();
  endtask

  task automatic test_wrap();
    exp_t e;
    logic msb;
    cpu_write(SL_ADDR_LO, 8'hFE);
    cpu_write(SL_ADDR_HI, 8'h00);
    frame_latch();
    exp_q.push_back('{name: "wrap_preload", v: ev(8'hFE, 1'b0, 1'b1, 1'b0, 1'b1)});
    bus.hblank = 1'b0; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    // Pulse m after preload: counter shows 0xFF before pulse 3 and again before 259.
    for (int m = 1; m <= 262; m++) begin
      msb = (m >= 3 && m < 259);
      exp_q.push_back('{name: $sformatf("wrap_m%0d", m), v: ev(8'hFE, 1'b1, 1'b0, msb, 1'b1)});
      pulse();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    end
    exp_q.push_back('{name: "wrap_end", v: ev(8'hFE, 1'b1, 1'b1, 1'b0, 1'b1)});
    bus.hblank = 1'b1; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
  endtask

  task automatic test_write_race();
    exp_t e;
    exp_q.push_back('{name: "race_old", v: ev(8'hFE, 1'b0, 1'b1, 1'b0, 1'b1)});
    exp_q.push_back('{name: "race_new", v: ev(8'h55, 1'b0, 1'b1, 1'b0, 1'b1)});
    // Write lands on the very clk of the vblank-rise enable.
    @(negedge clk);
    bus.vblank = 1'b1; cen = 1'b1;
    bus.cpu_wr = 1'b1; bus.cpu_addr = SL_ADDR_LO; bus.cpu_din = 8'h55;
    @(negedge clk);
    cen = 1'b0; bus.cpu_wr = 1'b0;
    @(negedge clk);
    bus.vblank = 1'b0; pulse();
    bus.hblank = 1'b0; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    pulse();
    bus.hblank = 1'b1; pulse();
    frame_latch();
    bus.hblank = 1'b0; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    pulse();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    exp_q.push_back('{name: "mid_run", v: ev(8'h55, 1'b1, 1'b0, 1'b0, 1'b1)});
    exp_q.push_back('{name: "mid_reset", v: ev(8'h00, 1'b1, 1'b1, 1'b0, 1'b1)});
    exp_q.push_back('{name: "no_preload", v: ev(8'h00, 1'b1, 1'b1, 1'b0, 1'b1)});
    exp_q.push_back('{name: "post_rst_preload", v: ev(8'h00, 1'b0, 1'b1, 1'b0, 1'b1)});
    exp_q.push_back('{name: "en_off_run", v: ev(8'h00, 1'b1, 1'b1, 1'b0, 1'b1)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    Reset_n = 1'b0;
    @(negedge clk) Reset_n = 1'b1;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    bus.hblank = 1'b1; pulse();
    bus.hblank = 1'b0; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    bus.hblank = 1'b1; pulse();
  endtask

  task automatic test_flip();
    exp_t e;
    logic msb;
    bus.flip = 1'b1;
    cpu_write(SL_ADDR_LO, 8'h34);
    cpu_write(SL_ADDR_HI, 8'h00);
    cpu_write(SL_ADDR_CTRL, 8'h01);
    frame_latch();
    exp_q.push_back('{name: "flip_preload", v: ev(8'hCB, 1'b0, 1'b1, 1'b1, 1'b0)});
    bus.hblank = 1'b0; pulse();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    // Counting down from 0xCB, Q shows 0x00 before pulse 205.
    for (int m = 1; m <= 206; m++) begin
      msb = (m < 205);
      exp_q.push_back('{name: $sformatf("flip_m%0d", m), v: ev(8'hCB, 1'b1, 1'b0, msb, 1'b0)});
      pulse();
      e = exp_q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, obs(), e.v); end
    end
    bus.hblank = 1'b1; pulse();
    bus.flip = 1'b0;
  endtask

  initial begin
    Reset_n      = 1'b0;
    cen          = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 2'd0;
    bus.cpu_din  = 8'h00;
    bus.hblank   = 1'b0;
    bus.vblank   = 1'b0;
    bus.flip     = 1'b0;
    test_reset();
    test_preload();
    test_cen_held();
    test_wrap();
    test_write_race();
    test_reset_mid();
`ifdef SCROLL_FLIP_EN
    test_flip();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
